// File: rtl/square_iter_pkg.sv
// Shared fixed-point constants and FSM encoding for the VAE
// square/square-root stages (signed Q4.11 words by default).
package square_iter_pkg;

    localparam int BITSIZE_DEF = 16;
    localparam int FRAC_DEF    = 11;

    localparam logic [BITSIZE_DEF-1:0] SAT_MAX =
        {1'b0, {(BITSIZE_DEF-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_t;

    function automatic logic [BITSIZE_DEF-1:0] abs_mag(
        input logic [BITSIZE_DEF-1:0] v
    );
        // Most-negative input maps onto itself: 0x8000 -> 0x8000
        // as an unsigned magnitude.
        return v[BITSIZE_DEF-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/square_iter_fx_round_sat.sv
// Round-half-up and saturate a 2W-bit unsigned product back to W bits.
// Ports: acc (product), data (rounded/clipped result), sat (clip flag).
module fx_round_sat
    import square_iter_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic [2*BITSIZE-1:0] acc,
    output logic [BITSIZE-1:0]   data,
    output logic                 sat
);

    // One spare bit so the rounding add can never wrap.
    localparam int AW = 2*BITSIZE + 1;

    localparam logic [AW-1:0] HALF  = AW'(1) << (FRAC-1);
    localparam logic [AW-1:0] LIMIT = (AW'(1) << (BITSIZE-1)) - AW'(1);

    logic [AW-1:0] sum;
    logic [AW-1:0] r;

    always_comb begin
        sum  = {1'b0, acc} + HALF;
        r    = sum >> FRAC;
        sat  = (r > LIMIT);
        data = sat ? LIMIT[BITSIZE-1:0] : r[BITSIZE-1:0];
    end

endmodule

// File: rtl/square_iter.sv
// Iterative shift-add squarer y = x*x on signed fixed-point words.
// Ports: clk, reset (async low), in_valid/in_ready/data_in,
//        out_valid/out_ready/data_out, sat (clip flag).
module square_iter
    import square_iter_pkg::*;
#(
    parameter int BITSIZE = BITSIZE_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] data_out,
    output logic               sat
);

    localparam int CW = $clog2(BITSIZE);
    localparam logic [CW-1:0] LAST = CW'(BITSIZE-1);

    state_t              state;
    state_t              state_nxt;
    logic [BITSIZE-1:0]  mag;
    logic [BITSIZE-1:0]  mag_in;
    logic [2*BITSIZE-1:0] acc;
    logic [2*BITSIZE-1:0] addend;
    logic [CW-1:0]       cnt;
    logic [BITSIZE-1:0]  rs_data;
    logic                rs_sat;

    fx_round_sat #(
        .BITSIZE(BITSIZE),
        .FRAC   (FRAC)
    ) u_rs (
        .acc (acc),
        .data(rs_data),
        .sat (rs_sat)
    );

    always_comb begin
        mag_in = data_in[BITSIZE-1] ? (~data_in + 1'b1) : data_in;
    end

    // Partial product for the current multiplier bit.
    always_comb begin
        addend = '0;
        if (mag[cnt])
            addend = {{BITSIZE{1'b0}}, mag} << cnt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = CALC;
            end
            CALC: begin
                if (cnt == LAST)
                    state_nxt = NORM;
            end
            NORM: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mag      <= '0;
            acc      <= '0;
            cnt      <= '0;
            data_out <= '0;
            sat      <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag <= mag_in;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + addend;
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    data_out <= rs_data;
                    sat      <= rs_sat;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_iter.sv
// Directed self-checking bench for square_iter.
// Table of operands plus hand sequences for reset and backpressure.
module tb_square_iter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        sat;

    int errors = 0;
    int checks = 0;

    square_iter dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] d;
        logic        s;
        string       name;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(
        input  logic [15:0] x,
        output logic [15:0] d,
        output logic        s,
        output int          lat
    );
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        data_in  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            data_in = 16'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        d = data_out;
        s = sat;
    endtask

    logic [15:0] d;
    logic        s;
    logic [15:0] held;
    int          lat;
    int          seen;

    initial begin
        tbl[0]  = '{16'h0400, 16'h0200, 1'b0, "half"};
        tbl[1]  = '{16'h0800, 16'h0800, 1'b0, "one"};
        tbl[2]  = '{16'h1000, 16'h2000, 1'b0, "two"};
        tbl[3]  = '{16'hF800, 16'h0800, 1'b0, "neg_one"};
        tbl[4]  = '{16'h0020, 16'h0001, 1'b0, "round_half"};
        tbl[5]  = '{16'h0B50, 16'h0FFF, 1'b0, "sqrt2"};
        tbl[6]  = '{16'h0001, 16'h0000, 1'b0, "tiny"};
        tbl[7]  = '{16'h2000, 16'h7FFF, 1'b1, "sat_four"};
        tbl[8]  = '{16'h8000, 16'h7FFF, 1'b1, "sat_min"};
        tbl[9]  = '{16'h16A0, 16'h3FFD, 1'b0, "sqrt8"};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, "zero"};

        reset     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_sat", int'(sat), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].x, d, s, lat);
            check({tbl[i].name, "_data"}, int'(d), int'(tbl[i].d));
            check({tbl[i].name, "_sat"}, int'(s), int'(tbl[i].s));
            check({tbl[i].name, "_lat"}, lat, 17);
        end

        // Mid-stream reset clears the held result.
        run_op(16'h0400, d, s, lat);
        check("pre_rst_data", int'(d), 16'h0200);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'h1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(data_out), 0);
        check("mid_rst_sat", int'(sat), 0);
        @(negedge clk);
        reset = 1'b1;

        // Backpressure.
        out_ready = 1'b0;
        run_op(16'h0800, d, s, lat);
        check("bp_lat", lat, 17);
        held = data_out;
        check("bp_data", int'(held), 16'h0800);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'h1000;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", int'(data_out), int'(held));
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drop_valid", int'(out_valid), 0);
        check("bp_in_ready_back", int'(in_ready), 1);
        check("bp_data_kept", int'(data_out), 16'h0800);
        @(posedge clk);
        #1;
        check("bp_no_accept", int'(in_ready), 1);

        // One-cycle reset pulse during CALC cycle 5.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 16'h1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid)
                seen++;
        end
        check("pulse_no_result", seen, 0);
        check("pulse_in_ready", int'(in_ready), 1);
        run_op(16'h0C00, d, s, lat);
        check("after_pulse_data", int'(d), 16'h1200);
        check("after_pulse_sat", int'(s), 0);
        check("after_pulse_lat", lat, 17);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
